// File: rtl/motor_serial_link_if.sv
// Handshake/control bundle between a motor controller host
// and the motor_serial_link board driver.
interface motor_serial_link_if #(
  parameter int NUM_MOTORS = 16
);
  logic                  start_i;
  logic [NUM_MOTORS-1:0] boost_i;
  logic [NUM_MOTORS-1:0] dir_i;
  logic [NUM_MOTORS-1:0] en_i;
  logic [NUM_MOTORS-1:0] step_i;
  logic [NUM_MOTORS-1:0] pfail_o;
  logic [NUM_MOTORS-1:0] sw_outa_o;
  logic [NUM_MOTORS-1:0] sw_outb_o;
  logic                  busy_o;
  logic                  valid_o;
  logic                  sclk_o;
  logic                  mosi_o;
  logic                  latch_o;
  logic                  load_n_o;
  logic                  miso_i;

  modport master (
    output start_i, boost_i, dir_i, en_i, step_i, miso_i,
    input  pfail_o, sw_outa_o, sw_outb_o, busy_o, valid_o,
    input  sclk_o, mosi_o, latch_o, load_n_o
  );

  modport slave (
    input  start_i, boost_i, dir_i, en_i, step_i, miso_i,
    output pfail_o, sw_outa_o, sw_outb_o, busy_o, valid_o,
    output sclk_o, mosi_o, latch_o, load_n_o
  );
endinterface

// File: rtl/motor_serial_link.sv
// Serial exchange with a motor board: control bits out through a
// latched shift chain, status bits in through a parallel-load chain.
module motor_serial_link #(
  parameter int NUM_MOTORS = 16,
  parameter int CLK_DIV    = 4
) (
  input logic                clk,
  input logic                rst_n,
  motor_serial_link_if.slave bus
);
  localparam int TXW = 4 * NUM_MOTORS;
  localparam int RXW = 3 * NUM_MOTORS;
  localparam int CW  = $clog2(CLK_DIV + 1);
  localparam int BW  = $clog2(TXW + 1);
  localparam logic [CW-1:0] PH_LAST  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(TXW - 1);
  localparam logic [BW-1:0] RX_BITS  = BW'(RXW);

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT, LATCH, DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         ph_q;
  logic                  hi_q;
  logic [BW-1:0]         bit_q;
  logic [TXW-1:0]        tx_q;
  logic [RXW-1:0]        rx_q;
  logic                  mosi_q;
  logic [NUM_MOTORS-1:0] pfail_q;
  logic [NUM_MOTORS-1:0] outa_q;
  logic [NUM_MOTORS-1:0] outb_q;
  logic [TXW-1:0]        snap;
  logic                  ph_end;
  logic                  bit_end;

  assign ph_end  = (ph_q == PH_LAST);
  assign bit_end = (bit_q == BIT_LAST);

  // Pack controls so the top bit is motor N boost, then dir, en, step.
  always_comb begin
    snap = '0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      snap[4*i+3] = bus.boost_i[i];
      snap[4*i+2] = bus.dir_i[i];
      snap[4*i+1] = bus.en_i[i];
      snap[4*i]   = bus.step_i[i];
    end
  end

  // Next-state sequencing of the frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start_i) state_d = LOAD;
      LOAD:    if (ph_end) state_d = SHIFT;
      SHIFT:   if (ph_end && hi_q && bit_end) state_d = LATCH;
      LATCH:   if (ph_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Phase/bit counters, shift registers and status capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q    <= '0;
      hi_q    <= 1'b0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      mosi_q  <= 1'b0;
      pfail_q <= '0;
      outa_q  <= '0;
      outb_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ph_q  <= '0;
          hi_q  <= 1'b0;
          bit_q <= '0;
          if (bus.start_i) tx_q <= snap;
        end
        LOAD: begin
          ph_q <= ph_end ? '0 : ph_q + CW'(1);
          if (ph_end) begin
            mosi_q <= tx_q[TXW-1];
            tx_q   <= {tx_q[TXW-2:0], 1'b0};
          end
        end
        SHIFT: begin
          ph_q <= ph_end ? '0 : ph_q + CW'(1);
          if (ph_end) begin
            hi_q <= ~hi_q;
            if (!hi_q && (bit_q < RX_BITS))
              rx_q <= {rx_q[RXW-2:0], bus.miso_i};
            if (hi_q) begin
              bit_q  <= bit_q + BW'(1);
              mosi_q <= bit_end ? 1'b0 : tx_q[TXW-1];
              tx_q   <= {tx_q[TXW-2:0], 1'b0};
            end
          end
        end
        LATCH: begin
          ph_q <= ph_end ? '0 : ph_q + CW'(1);
          if (ph_end) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
              pfail_q[i] <= rx_q[3*i+2];
              outb_q[i]  <= rx_q[3*i+1];
              outa_q[i]  <= rx_q[3*i];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o    = (state_q == LOAD) || (state_q == SHIFT) ||
                         (state_q == LATCH);
  assign bus.valid_o   = (state_q == DONE);
  assign bus.load_n_o  = (state_q != LOAD);
  assign bus.latch_o   = (state_q == LATCH);
  assign bus.sclk_o    = hi_q;
  assign bus.mosi_o    = mosi_q;
  assign bus.pfail_o   = pfail_q;
  assign bus.sw_outa_o = outa_q;
  assign bus.sw_outb_o = outb_q;
endmodule

// File: tb/tb_motor_serial_link.sv
// Bench for motor_serial_link: frame-level model plus a small
// second instance with CLK_DIV=1, NUM_MOTORS=2.
module tb_motor_serial_link;
  localparam int M    = 16;
  localparam int D    = 4;
  localparam int BUSY = (2 + 8 * M) * D;
  localparam int SHE  = D + 8 * M * D;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  motor_serial_link_if #(.NUM_MOTORS(M)) bus ();
  motor_serial_link #(.NUM_MOTORS(M), .CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  motor_serial_link_if #(.NUM_MOTORS(2)) bus2 ();
  motor_serial_link #(.NUM_MOTORS(2), .CLK_DIV(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Frame model: mt = cycles since the accepting edge (0 = idle).
  int mt = 0;
  logic [M-1:0] b_pf, b_oa, b_ob;
  logic [M-1:0] f_pf, f_oa, f_ob;
  logic [M-1:0] f_bo, f_di, f_en, f_st;
  logic [M-1:0] e_pf = '0, e_oa = '0, e_ob = '0;
  logic chk_on = 1'b0;

  function automatic logic ser_tx(int b);
    int i;
    i = M - 1 - b / 4;
    case (b % 4)
      0:       return f_bo[i];
      1:       return f_di[i];
      2:       return f_en[i];
      default: return f_st[i];
    endcase
  endfunction

  function automatic logic ser_rx(int k);
    int i;
    if (k >= 3 * M) return 1'b1;
    i = M - 1 - k / 3;
    case (k % 3)
      0:       return f_pf[i];
      1:       return f_ob[i];
      default: return f_oa[i];
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mt = 0;
      e_pf = '0; e_oa = '0; e_ob = '0;
    end else if (mt == 0) begin
      if (bus.start_i) begin
        mt = 1;
        f_bo = bus.boost_i; f_di = bus.dir_i;
        f_en = bus.en_i;    f_st = bus.step_i;
        f_pf = b_pf; f_oa = b_oa; f_ob = b_ob;
      end
    end else if (mt == BUSY + 1) begin
      mt = 0;
    end else begin
      mt++;
      if (mt == BUSY + 1) begin
        e_pf = f_pf; e_oa = f_oa; e_ob = f_ob;
      end
    end
  end

  // Board input chain: present status bit of the current period.
  always @(negedge clk) begin
    int s;
    s = mt - D - 1;
    if (mt > D && mt <= SHE) bus.miso_i = ser_rx(s / (2 * D));
    else                     bus.miso_i = 1'b0;
  end

  // Cycle compare against the model.
  always @(negedge clk) begin
    logic e_sh, e_hi;
    int s, b;
    if (rst_n && chk_on) begin
      e_sh = (mt > D) && (mt <= SHE);
      s = mt - D - 1;
      b = e_sh ? s / (2 * D) : 0;
      e_hi = e_sh && ((s % (2 * D)) >= D);
      chk("busy", bus.busy_o, (mt >= 1) && (mt <= BUSY));
      chk("valid", bus.valid_o, mt == BUSY + 1);
      chk("load_n", bus.load_n_o, !((mt >= 1) && (mt <= D)));
      chk("latch", bus.latch_o, (mt > BUSY - D) && (mt <= BUSY));
      chk("sclk", bus.sclk_o, e_hi);
      if (e_sh) chk("mosi", bus.mosi_o, ser_tx(b));
      chk("pfail", bus.pfail_o, e_pf);
      chk("sw_outa", bus.sw_outa_o, e_oa);
      chk("sw_outb", bus.sw_outb_o, e_ob);
    end
  end

  int rises = 0, hi_cnt = 0, hi_idx = 0, vcount = 0;
  logic prev_sclk = 1'b0;
  always @(negedge clk) begin
    if (bus.sclk_o && !prev_sclk) begin
      rises++;
      if (bus.mosi_o) begin
        hi_cnt++;
        hi_idx = rises - 1;
      end
    end
    prev_sclk = bus.sclk_o;
    if (bus.valid_o) vcount++;
  end

  task automatic pulse_start();
    @(posedge clk); #1 bus.start_i = 1'b1;
    @(posedge clk); #1 bus.start_i = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.valid_o && k < 2000);
    if (!bus.valid_o) chk("valid_timeout", bus.valid_o, 1);
  endtask

  task automatic set_ctrl(input logic [M-1:0] bo, di, en, st);
    bus.boost_i = bo; bus.dir_i = di;
    bus.en_i = en;    bus.step_i = st;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, g, r0, h0, v0, bc, rr1, rr2, m0;
    logic act, p2;
    bus.start_i = 1'b0;
    set_ctrl('0, '0, '0, '0);
    b_pf = '0; b_oa = '0; b_ob = '0;
    bus2.start_i = 1'b0; bus2.miso_i = 1'b0;
    bus2.boost_i = '0; bus2.dir_i = '0;
    bus2.en_i = '0;    bus2.step_i = '0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_sclk", bus.sclk_o, 0);
    chk("rst_mosi", bus.mosi_o, 0);
    chk("rst_latch", bus.latch_o, 0);
    chk("rst_load_n", bus.load_n_o, 1);
    chk("rst_pfail", bus.pfail_o, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_on = 1'b1;

    // Idle with no start for 100 cycles.
    act = 1'b0;
    repeat (100) begin
      @(negedge clk);
      act |= bus.busy_o | bus.valid_o | bus.sclk_o | bus.mosi_o |
             bus.latch_o | !bus.load_n_o | (|bus.pfail_o) |
             (|bus.sw_outa_o) | (|bus.sw_outb_o);
    end
    chk("idle_quiet", act, 0);

    // Single boost bit on motor 1.
    set_ctrl(16'h0001, '0, '0, '0);
    r0 = rises; h0 = hi_cnt;
    pulse_start();
    wait_valid(k);
    chk("lat_valid", k, 521);
    chk("sclk_rises", rises - r0, 64);
    chk("mosi_hi_cnt", hi_cnt - h0, 1);
    chk("mosi_hi_idx", hi_idx - r0, 60);

    // Status capture plus mid-frame control changes.
    b_pf = 16'h8000; b_oa = 16'h0001; b_ob = 16'hA5A5;
    set_ctrl(16'h1234, 16'hFACE, 16'h0F0F, 16'h8001);
    pulse_start();
    repeat (100) @(negedge clk);
    set_ctrl(16'hEDCB, 16'h0531, 16'hF0F0, 16'h7FFE);
    wait_valid(k);
    chk("st_pfail", bus.pfail_o, 16'h8000);
    chk("st_outa", bus.sw_outa_o, 16'h0001);
    chk("st_outb", bus.sw_outb_o, 16'hA5A5);
    repeat (20) @(negedge clk);
    chk("hold_outb", bus.sw_outb_o, 16'hA5A5);

    // start_i held high: back-to-back frames.
    b_pf = 16'h00FF; b_oa = 16'h3C3C; b_ob = 16'h1111;
    set_ctrl(16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000);
    @(posedge clk); #1 bus.start_i = 1'b1;
    wait_valid(k);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!bus.busy_o && g < 10);
    chk("b2b_gap", g, 2);
    wait_valid(k);
    chk("b2b_len", k, 520);
    bus.start_i = 1'b0;
    chk("b2b_pfail", bus.pfail_o, 16'h00FF);

    // Reset pulse in the middle of a frame.
    b_pf = 16'h0F00; b_oa = 16'hBEEF; b_ob = 16'h1234;
    pulse_start();
    repeat (200) @(negedge clk);
    v0 = vcount;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy_o, 0);
    chk("abort_load_n", bus.load_n_o, 1);
    chk("abort_sclk", bus.sclk_o, 0);
    chk("abort_pfail", bus.pfail_o, 0);
    chk("abort_outa", bus.sw_outa_o, 0);
    chk("abort_outb", bus.sw_outb_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.start_i = 1'b1;
    chk("abort_novalid", vcount - v0, 0);
    @(posedge clk); #1 bus.start_i = 1'b0;
    @(negedge clk);
    chk("first_start", bus.busy_o, 1);
    wait_valid(k);
    chk("recover_len", k, 520);
    chk("recover_outa", bus.sw_outa_o, 16'hBEEF);

    // Small instance: CLK_DIV=1, NUM_MOTORS=2.
    bus2.boost_i = 2'b10;
    @(posedge clk); #1 bus2.start_i = 1'b1;
    @(posedge clk); #1 bus2.start_i = 1'b0;
    bc = 0; rr1 = -1; rr2 = -1; m0 = 0; p2 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus2.busy_o) bc++;
      if (bus2.sclk_o && !p2) begin
        if (rr1 < 0) begin
          rr1 = c;
          m0 = bus2.mosi_o;
        end else if (rr2 < 0) begin
          rr2 = c;
        end
      end
      p2 = bus2.sclk_o;
      if (bus2.valid_o) break;
    end
    chk("d2_busy", bc, 18);
    chk("d2_sclk_per", rr2 - rr1, 2);
    chk("d2_mosi0", m0, 1);
    chk("d2_valid", bus2.valid_o, 1);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
